// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - split-transaction data bus between the memory stage and data memory
interface memory_stage_if;
  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store pipeline stage between execute and writeback
module memory_stage #(
  parameter int DEST_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_regwrite,
  input  logic [PC_W-1:0]   in_pc,
  memory_stage_if.master    dbus,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_regwrite,
  output logic              out_exc_adel,
  output logic              out_exc_ades,
  output logic [31:0]       out_badvaddr,
  output logic [PC_W-1:0]   out_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;

  // Latched memory op, held while the bus transaction is outstanding
  logic              killed;
  logic              op_write;
  logic              op_signed;
  logic              op_regwrite;
  logic [1:0]        op_size;
  logic [31:0]       op_addr;
  logic [31:0]       op_data;
  logic [3:0]        op_strobe;
  logic [DEST_W-1:0] op_dest;
  logic [PC_W-1:0]   op_pc;

  logic        is_mem, is_word, is_half, misaligned, exc;
  logic        accept, start_mem, direct, complete, deliver;
  logic [3:0]  strobe_n;
  logic [31:0] lanes_n, shifted, load_val;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign start_mem = accept && is_mem && !misaligned;
  assign direct    = accept && !(is_mem && !misaligned);
  assign exc       = is_mem && misaligned;

  assign dbus.dreq_valid  = (state == REQ);
  assign dbus.dreq_write  = op_write;
  assign dbus.dreq_addr   = op_addr;
  assign dbus.dreq_strobe = op_strobe;
  assign dbus.dreq_data   = op_data;

  // Decode the incoming op: alignment check and store lane steering
  always_comb begin
    is_mem     = in_memread | in_memwrite;
    is_word    = in_size[1];
    is_half    = (in_size == 2'd1);
    misaligned = (is_half && in_addr[0]) || (is_word && (in_addr[1:0] != 2'b00));
    if (is_word) begin
      strobe_n = 4'hF;
      lanes_n  = in_wdata;
    end else if (is_half) begin
      strobe_n = 4'b0011 << in_addr[1:0];
      lanes_n  = {2{in_wdata[15:0]}};
    end else begin
      strobe_n = 4'b0001 << in_addr[1:0];
      lanes_n  = {4{in_wdata[7:0]}};
    end
    if (!in_memwrite) strobe_n = 4'h0;
  end

  // Align the returned word to the addressed byte and extend to 32 bits
  always_comb begin
    shifted = dbus.dresp_data >> {op_addr[1:0], 3'b000};
    case (op_size)
      2'd0:    load_val = {{24{op_signed & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{op_signed & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Next-state logic; a completion caught by a flush is dropped
  always_comb begin
    state_n  = state;
    complete = 1'b0;
    case (state)
      IDLE: if (start_mem) state_n = REQ;
      REQ: begin
        if (dbus.dresp_addr_ok) begin
          if (dbus.dresp_data_ok) complete = 1'b1;
          else                    state_n  = WAIT;
        end
      end
      WAIT: if (dbus.dresp_data_ok) complete = 1'b1;
      HOLD: if (flush || out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    deliver = complete && !killed && !flush;
    if (complete) state_n = (deliver && !out_ready) ? HOLD : IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Op latch, kill flag and the output register toward writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      killed       <= 1'b0;
      op_write     <= 1'b0;
      op_signed    <= 1'b0;
      op_regwrite  <= 1'b0;
      op_size      <= 2'd0;
      op_addr      <= 32'd0;
      op_data      <= 32'd0;
      op_strobe    <= 4'd0;
      op_dest      <= '0;
      op_pc        <= '0;
      out_valid    <= 1'b0;
      out_result   <= 32'd0;
      out_dest     <= '0;
      out_regwrite <= 1'b0;
      out_exc_adel <= 1'b0;
      out_exc_ades <= 1'b0;
      out_badvaddr <= 32'd0;
      out_pc       <= '0;
    end else begin
      if (flush && (state == REQ || state == WAIT)) killed <= 1'b1;
      if (complete) killed <= 1'b0;

      if (start_mem) begin
        op_write    <= in_memwrite;
        op_signed   <= in_signed;
        op_regwrite <= in_regwrite;
        op_size     <= in_size;
        op_addr     <= in_addr;
        op_data     <= lanes_n;
        op_strobe   <= strobe_n;
        op_dest     <= in_dest;
        op_pc       <= in_pc;
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (direct) begin
        out_valid    <= 1'b1;
        out_result   <= exc ? 32'd0 : in_addr;
        out_dest     <= in_dest;
        out_regwrite <= in_regwrite && !exc;
        out_exc_adel <= exc && !in_memwrite;
        out_exc_ades <= exc && in_memwrite;
        out_badvaddr <= exc ? in_addr : 32'd0;
        out_pc       <= in_pc;
      end else if (deliver) begin
        out_valid    <= 1'b1;
        out_result   <= op_write ? op_addr : load_val;
        out_dest     <= op_dest;
        out_regwrite <= op_regwrite && !op_write;
        out_exc_adel <= 1'b0;
        out_exc_ades <= 1'b0;
        out_badvaddr <= 32'd0;
        out_pc       <= op_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, in_memread, in_memwrite, in_signed, in_regwrite;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_dest;
  logic        out_valid, out_ready, out_regwrite, out_exc_adel, out_exc_ades;
  logic [31:0] out_result, out_badvaddr, out_pc;
  logic [4:0]  out_dest;

  int total = 0;
  int bad   = 0;

  memory_stage_if dbus();

  memory_stage #(.DEST_W(5), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_dest(in_dest), .in_regwrite(in_regwrite), .in_pc(in_pc),
    .dbus(dbus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_regwrite(out_regwrite), .out_exc_adel(out_exc_adel),
    .out_exc_ades(out_exc_ades), .out_badvaddr(out_badvaddr), .out_pc(out_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] addr);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] data, input logic [31:0] addr,
                                           input logic [1:0] sz, input logic sgn);
    int n = nbytes(sz);
    int off = int'(addr % 4);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = data[8*(off+i) +: 8];
    if (sgn && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] exp_strobe(input logic [1:0] sz, input logic [31:0] addr);
    int n = nbytes(sz);
    int off = int'(addr % 4);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [1:0] sz, input logic [31:0] wdata);
    int n = nbytes(sz);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wdata[8*(i % n) +: 8];
    return v;
  endfunction

  task automatic scramble_inputs();
    in_memread  = 1'($urandom);
    in_memwrite = 1'($urandom);
    in_size     = 2'($urandom);
    in_signed   = 1'($urandom);
    in_addr     = $urandom;
    in_wdata    = $urandom;
    in_dest     = 5'($urandom);
    in_regwrite = 1'($urandom);
    in_pc       = $urandom;
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest,
                       input logic rw, input logic [31:0] pc, input logic [31:0] rdata,
                       input int ao_dly, input int do_dly, input int stall, input logic kill);
    logic mem, mis;
    logic [31:0] e_res;
    int guard = 0;
    mem = rd | wr;
    mis = mem && misal(sz, addr);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before", in_ready, 1);
    in_valid = 1; in_memread = rd; in_memwrite = wr; in_size = sz; in_signed = sgn;
    in_addr = addr; in_wdata = wdata; in_dest = dest; in_regwrite = rw; in_pc = pc;
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    scramble_inputs();
    if (!mem || mis) begin
      e_res = mis ? 32'd0 : addr;
      check("no_dreq", dbus.dreq_valid, 0);
      check("out_valid", out_valid, 1);
      check("result", out_result, e_res);
      check("regwrite", out_regwrite, mis ? 1'b0 : rw);
      check("adel", out_exc_adel, mis && !wr);
      check("ades", out_exc_ades, mis && wr);
      if (mis) check("badvaddr", out_badvaddr, addr);
      check("dest", out_dest, dest);
      check("pc", out_pc, pc);
    end else begin
      for (int i = 0; i <= ao_dly; i++) begin
        check("dreq_valid", dbus.dreq_valid, 1);
        check("dreq_write", dbus.dreq_write, wr);
        check("dreq_addr", dbus.dreq_addr, addr);
        check("dreq_strobe", dbus.dreq_strobe, wr ? exp_strobe(sz, addr) : 4'd0);
        if (wr) check("dreq_data", dbus.dreq_data, exp_lanes(sz, wdata));
        check("req_no_out", out_valid, 0);
        out_ready = 1'($urandom);
        dbus.dresp_data_ok = (i < ao_dly) ? 1'($urandom) : 1'b0;
        if (i == ao_dly) begin
          dbus.dresp_addr_ok = 1;
          if (do_dly == 0) begin
            dbus.dresp_data_ok = 1;
            dbus.dresp_data = rdata;
          end
        end
        @(negedge clk);
      end
      dbus.dresp_addr_ok = 0;
      dbus.dresp_data_ok = 0;
      dbus.dresp_data = $urandom;
      check("dreq_drop", dbus.dreq_valid, 0);
      for (int j = 1; j <= do_dly; j++) begin
        check("wait_no_out", out_valid, 0);
        if (kill && j == 1) flush = 1;
        if (j == do_dly) begin
          dbus.dresp_data_ok = 1;
          dbus.dresp_data = rdata;
        end
        @(negedge clk);
        flush = 0;
        dbus.dresp_data_ok = 0;
        dbus.dresp_data = $urandom;
      end
      if (kill) begin
        check("killed_no_out", out_valid, 0);
        check("killed_idle", in_ready, 1);
        check("killed_no_dreq", dbus.dreq_valid, 0);
        return;
      end
      e_res = wr ? addr : exp_load(rdata, addr, sz, sgn);
      check("mem_out_valid", out_valid, 1);
      check("mem_result", out_result, e_res);
      check("mem_regwrite", out_regwrite, wr ? 1'b0 : rw);
      check("mem_exc", {out_exc_adel, out_exc_ades}, 2'b00);
      check("mem_dest", out_dest, dest);
      check("mem_pc", out_pc, pc);
    end
    if (stall > 0) begin
      out_ready = 0;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, e_res);
        check("hold_dest", out_dest, dest);
        check("hold_in_ready", in_ready, 0);
      end
    end
    out_ready = 1;
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
    check("drain_dreq", dbus.dreq_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int kind, n, dd;
    logic kl;
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_memread = 0; in_memwrite = 0; in_size = 0; in_signed = 0; in_addr = 0;
    in_wdata = 0; in_dest = 0; in_regwrite = 0; in_pc = 0;
    dbus.dresp_addr_ok = 0; dbus.dresp_data_ok = 0; dbus.dresp_data = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dreq_valid", dbus.dreq_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_exc", {out_exc_adel, out_exc_ades, out_regwrite}, 3'b000);

    do_op(0, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd1, 1, 32'h100, 32'h0, 0, 0, 0, 0);
    do_op(1, 0, 2'd0, 1, 32'h1003, 32'h0, 5'd2, 1, 32'h104, 32'h80FF_0000, 1, 2, 0, 0);
    do_op(1, 0, 2'd0, 0, 32'h1003, 32'h0, 5'd2, 1, 32'h108, 32'h80FF_0000, 1, 2, 0, 0);
    do_op(0, 1, 2'd1, 0, 32'h2002, 32'hAAAA_BEEF, 5'd3, 1, 32'h10C, 32'h0, 3, 1, 0, 0);
    do_op(1, 0, 2'd2, 0, 32'h3001, 32'h0, 5'd4, 1, 32'h110, 32'h0, 0, 0, 0, 0);
    do_op(0, 1, 2'd2, 0, 32'h3002, 32'h5, 5'd5, 1, 32'h114, 32'h0, 0, 0, 0, 0);
    do_op(1, 0, 2'd2, 0, 32'h4000, 32'h0, 5'd6, 1, 32'h118, 32'hDEAD_BEEF, 0, 2, 0, 1);
    do_op(1, 0, 2'd2, 0, 32'h4004, 32'h0, 5'd7, 1, 32'h11C, 32'hCAFE_F00D, 0, 0, 3, 0);

    // writeback stalled, then flushed while an accept is attempted
    in_valid = 1; in_memread = 0; in_memwrite = 0; in_addr = 32'h55; in_regwrite = 1;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    check("fl_out_valid", out_valid, 1);
    flush = 1; out_ready = 1; in_valid = 1; in_memread = 1; in_size = 2'd2; in_addr = 32'h100;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("fl_cleared", out_valid, 0);
    check("fl_no_accept", dbus.dreq_valid, 0);
    @(negedge clk);
    check("fl_still_idle", dbus.dreq_valid | out_valid, 0);

    // reset in the middle of a bus request
    in_valid = 1; in_memread = 1; in_memwrite = 0; in_size = 2'd2; in_addr = 32'h200;
    @(negedge clk);
    in_valid = 0;
    check("rm_req", dbus.dreq_valid, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rm_dreq", dbus.dreq_valid, 0);
    check("rm_ready", in_ready, 1);
    check("rm_out", out_valid, 0);

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom);
      n = nbytes(sz);
      a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a - (a % n);
      dd = $urandom_range(0, 3);
      kl = (kind != 0) && ($urandom_range(0, 9) == 0);
      if (kl && dd == 0) dd = 1;
      do_op(kind == 1, kind == 2, sz, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom_range(0, 3), dd, $urandom_range(0, 3), kl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
